pwm_ramp_scheduler: RTL and testbench

Multi-channel PWM controller that shares one free-running period counter among N channels.
Each channel's duty target is written over a valid/ready config port. The applied duty ramps toward the target in bounded steps, updating only at period boundaries, so outputs never glitch.
A global run/soft-stop FSM ramps every channel down to 0 before halting. The block sits between the switch/config front end and the output pins.

---
 rtl/pwm_sched_pkg.sv | 15 +
 rtl/pwm_ramp_step.sv | 31 +++
 rtl/pwm_ramp_scheduler.sv | 139 +++++++++++++
 tb/tb_pwm_ramp_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sched_pkg.sv
// Shared types and defaults for the PWM ramp scheduler.
// Defines the state encoding seen on the state output and the default duty width and step.
package pwm_sched_pkg;

    localparam int STATE_W  = 2;
    localparam int DEF_W    = 8;
    localparam int DEF_STEP = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// Single-channel ramp step: moves cur toward eff by at most STEP.
// The result lands exactly on eff and never wraps.
module pwm_ramp_step
    import pwm_sched_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int STEP = DEF_STEP
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] eff,
    output logic [W-1:0] nxt
);

    localparam logic [W-1:0] STEP_W = W'(STEP);

    logic [W-1:0] up_gap;
    logic [W-1:0] down_gap;

    assign up_gap   = eff - cur;
    assign down_gap = cur - eff;

    always_comb begin
        nxt = cur;
        if (cur < eff) begin
            nxt = (up_gap > STEP_W) ? cur + STEP_W : eff;
        end else if (cur > eff) begin
            nxt = (down_gap > STEP_W) ? cur - STEP_W : eff;
        end
    end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Multi-channel PWM sharing one period counter; duties ramp toward their targets on
// period boundaries, and a soft stop ramps every channel to 0 before halting.
module pwm_ramp_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int W        = DEF_W,
    parameter int STEP     = DEF_STEP,
    parameter int RAMP_DIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_en,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2:0]      wr_chan,
    input  logic [W-1:0]    wr_duty,
    output logic            wr_err,
    output logic [N_CH-1:0] pwm_out,
    output logic            period_start,
    output logic            busy,
    output logic [1:0]      state
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    sched_state_t     state_reg;
    logic [W-1:0]     cnt_reg;
    logic [DIV_W-1:0] div_reg;
    logic [W-1:0]     tgt_reg [N_CH];
    logic [W-1:0]     cur_reg [N_CH];
    logic [W-1:0]     eff     [N_CH];
    logic [W-1:0]     cur_next[N_CH];
    logic [N_CH-1:0]  pwm_reg;
    logic [N_CH-1:0]  pwm_next;
    logic [N_CH-1:0]  busy_vec;
    logic [N_CH-1:0]  next_zero;
    logic             wr_ready_reg;
    logic             wr_err_reg;
    logic             period_start_reg;
    logic             period_end;
    logic             tick;
    logic             wr_fire;
    logic             chan_bad;

    assign period_end = (cnt_reg == '1);
    assign tick       = period_end && (div_reg == DIV_LAST);
    assign wr_fire    = wr_valid && wr_ready_reg;
    assign chan_bad   = ({1'b0, wr_chan} >= 4'(N_CH));

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            // Soft stop is expressed purely as a zero effective target.
            assign eff[gi] = (state_reg == ST_RUN) ? tgt_reg[gi] : '0;

            pwm_ramp_step #(.W(W), .STEP(STEP)) u_step (
                .cur (cur_reg[gi]),
                .eff (eff[gi]),
                .nxt (cur_next[gi])
            );

            assign pwm_next[gi]  = (state_reg != ST_STOPPED) && (cnt_reg < cur_reg[gi]);
            assign busy_vec[gi]  = (cur_reg[gi] != eff[gi]);
            assign next_zero[gi] = (cur_next[gi] == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_STOPPED;
            cnt_reg          <= '0;
            div_reg          <= '0;
            pwm_reg          <= '0;
            wr_ready_reg     <= 1'b0;
            wr_err_reg       <= 1'b0;
            period_start_reg <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                tgt_reg[i] <= '0;
                cur_reg[i] <= '0;
            end
        end else begin
            wr_ready_reg     <= 1'b1;
            wr_err_reg       <= wr_fire && chan_bad;
            period_start_reg <= period_end && (state_reg != ST_STOPPED);
            pwm_reg          <= pwm_next;

            // A write landing on a tick edge is seen by the following tick only.
            for (int i = 0; i < N_CH; i++) begin
                if (wr_fire && (wr_chan == 3'(i))) begin
                    tgt_reg[i] <= wr_duty;
                end
                if (tick) begin
                    cur_reg[i] <= cur_next[i];
                end
            end

            if (state_reg == ST_STOPPED) begin
                cnt_reg <= '0;
                div_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                if (period_end) begin
                    div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
                end
            end

            case (state_reg)
                ST_STOPPED: begin
                    if (run_en) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run_en) begin
                        state_reg <= ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    if (run_en) begin
                        state_reg <= ST_RUN;
                    end else if (tick && (&next_zero)) begin
                        state_reg <= ST_STOPPED;
                        cnt_reg   <= '0;
                    end
                end
                default: state_reg <= ST_STOPPED;
            endcase
        end
    end

    assign wr_ready     = wr_ready_reg;
    assign wr_err       = wr_err_reg;
    assign pwm_out      = pwm_reg;
    assign period_start = period_start_reg;
    assign busy         = |busy_vec;
    assign state        = state_reg;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Self-checking bench for pwm_ramp_scheduler: measures each period's duty from pwm_out
// and compares against a per-tick arithmetic model of targets and applied duties.
module tb_pwm_ramp_scheduler;

    localparam int N   = 4;
    localparam int STP = 16;
    localparam int PER = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_en;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_chan;
    logic [7:0] wr_duty;
    logic       wr_err;
    logic [3:0] pwm_out;
    logic       period_start;
    logic       busy;
    logic [1:0] state;

    pwm_ramp_scheduler #(.N_CH(4), .W(8), .STEP(16), .RAMP_DIV(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .run_en       (run_en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_chan      (wr_chan),
        .wr_duty      (wr_duty),
        .wr_err       (wr_err),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy),
        .state        (state)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: 0=stopped, 1=run, 2=stopping
    int m_tgt[N];
    int m_cur[N];
    int m_state;

    // One pending mid-period action per run_periods call: 0 none, 1 write, 2 run_en change
    int act_kind   = 0;
    int act_period = 0;
    int act_ch     = 0;
    int act_duty   = 0;
    int act_run    = 0;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_tgt[i] = 0;
            m_cur[i] = 0;
        end
        m_state = 0;
    endfunction

    function automatic int m_eff(input int i);
        return (m_state == 1) ? m_tgt[i] : 0;
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < N; i++) begin
            if (m_cur[i] != m_eff(i)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_tick();
        int all_zero;
        all_zero = 1;
        for (int i = 0; i < N; i++) begin
            int e;
            e = m_eff(i);
            if (m_cur[i] < e) m_cur[i] = (m_cur[i] + STP < e) ? m_cur[i] + STP : e;
            else if (m_cur[i] > e) m_cur[i] = (m_cur[i] - STP > e) ? m_cur[i] - STP : e;
            if (m_cur[i] != 0) all_zero = 0;
        end
        if (m_state == 2 && all_zero == 1) m_state = 0;
    endfunction

    task automatic run_periods(input string name, input int n);
        int guard;
        int hi[N];
        int ps_extra;
        bit wr_pend;
        logic [1:0] exp_st;
        guard = 0;
        while (!period_start && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (!period_start) begin
            tests_failed++;
            $display("FAIL %s sync: period_start=%0b after %0d cycles, required 1", name, period_start, guard);
            act_kind = 0;
            return;
        end
        for (int p = 0; p < n; p++) begin
            m_tick();
            for (int i = 0; i < N; i++) hi[i] = 0;
            ps_extra = 0;
            wr_pend  = 1'b0;
            for (int k = 1; k <= PER; k++) begin
                @(negedge clk);
                if (wr_pend) begin
                    wr_valid = 1'b0;
                    wr_pend  = 1'b0;
                    tests_run++;
                    if (wr_err !== (act_ch >= N)) begin
                        tests_failed++;
                        $display("FAIL %s wr_err: got %0b, required %0b", name, wr_err, act_ch >= N);
                    end
                    if (act_ch < N) m_tgt[act_ch] = act_duty;
                end
                for (int i = 0; i < N; i++) hi[i] += (pwm_out[i] === 1'b1) ? 1 : 0;
                if (k < PER && period_start !== 1'b0) ps_extra++;
                if (k == 200) begin
                    exp_st = m_state[1:0];
                    tests_run++;
                    if (state !== exp_st) begin
                        tests_failed++;
                        $display("FAIL %s p%0d state: got %0d, required %0d", name, p, state, exp_st);
                    end
                    tests_run++;
                    if (busy !== m_busy()) begin
                        tests_failed++;
                        $display("FAIL %s p%0d busy: got %0b, required %0b", name, p, busy, m_busy());
                    end
                end
                if (k == 100 && p == act_period) begin
                    if (act_kind == 1) begin
                        wr_valid = 1'b1;
                        wr_chan  = act_ch[2:0];
                        wr_duty  = act_duty[7:0];
                        wr_pend  = 1'b1;
                    end else if (act_kind == 2) begin
                        run_en = act_run[0];
                        if (act_run != 0 && m_state != 1) m_state = 1;
                        if (act_run == 0 && m_state == 1) m_state = 2;
                    end
                end
            end
            $display("[TB] %s period %0d duty=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d state=%0d",
                     name, p, hi[0], hi[1], hi[2], hi[3], m_cur[0], m_cur[1], m_cur[2], m_cur[3], state);
            for (int i = 0; i < N; i++) begin
                tests_run++;
                if (hi[i] != m_cur[i]) begin
                    tests_failed++;
                    $display("FAIL %s p%0d ch%0d duty: got %0d, required %0d", name, p, i, hi[i], m_cur[i]);
                end
            end
            tests_run++;
            if (ps_extra != 0) begin
                tests_failed++;
                $display("FAIL %s p%0d stray period_start: got %0d, required 0", name, p, ps_extra);
            end
            tests_run++;
            if (period_start !== (m_state != 0)) begin
                tests_failed++;
                $display("FAIL %s p%0d period_start at wrap: got %0b, required %0b", name, p, period_start, m_state != 0);
            end
            if (m_state == 0) break;
        end
        act_kind = 0;
    endtask

    task automatic start_run(input string name);
        int cyc;
        int bad_pwm;
        run_en  = 1'b1;
        m_state = 1;
        cyc     = 0;
        bad_pwm = 0;
        while (period_start !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pwm_out !== 4'b0000) bad_pwm++;
        end
        $display("[TB] %s first period_start after %0d cycles", name, cyc);
        tests_run++;
        if (cyc != PER + 1) begin
            tests_failed++;
            $display("FAIL %s first period_start latency: got %0d, required %0d", name, cyc, PER + 1);
        end
        tests_run++;
        if (bad_pwm != 0) begin
            tests_failed++;
            $display("FAIL %s pwm before first tick: got %0d high samples, required 0", name, bad_pwm);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (period_start !== 1'b0 || pwm_out !== 4'b0000 || state !== 2'd0) bad++;
        end
        $display("[TB] %s idle %0d cycles, %0d active samples", name, cycles, bad);
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s idle activity: got %0d active samples, required 0", name, bad);
        end
    endtask

    task automatic write_stopped(input int ch, input int duty);
        wr_valid = 1'b1;
        wr_chan  = ch[2:0];
        wr_duty  = duty[7:0];
        @(negedge clk);
        wr_valid = 1'b0;
        $display("[TB] write ch%0d=%0d wr_err=%0b", ch, duty, wr_err);
        tests_run++;
        if (wr_err !== (ch >= N)) begin
            tests_failed++;
            $display("FAIL write_stopped wr_err: got %0b, required %0b", wr_err, ch >= N);
        end
        if (ch < N) m_tgt[ch] = duty;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        run_en   = 1'b0;
        wr_valid = 1'b0;
        wr_chan  = 3'd0;
        wr_duty  = 8'd0;
        m_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (wr_ready !== 1'b0 || state !== 2'd0 || pwm_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_hold: wr_ready=%0b state=%0d pwm=%b, required 0/0/0000", wr_ready, state, pwm_out);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset released wr_ready=%0b state=%0d busy=%0b", wr_ready, state, busy);
        tests_run++;
        if (wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset wr_ready: got %0b, required 1", wr_ready);
        end
        tests_run++;
        if (state !== 2'd0 || busy !== 1'b0 || pwm_out !== 4'b0000 || period_start !== 1'b0 || wr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset outputs: state=%0d busy=%0b pwm=%b ps=%0b err=%0b, required all 0",
                     state, busy, pwm_out, period_start, wr_err);
        end
        check_idle("reset_idle", 300);
    endtask

    task automatic test_ramp_up();
        write_stopped(0, 128);
        start_run("ramp_up");
        run_periods("ramp_up", 9);
    endtask

    task automatic test_overshoot();
        act_kind = 1; act_period = 0; act_ch = 1; act_duty = 200;
        run_periods("ch1_ramp", 15);
    endtask

    task automatic test_mid_period_write();
        act_kind = 1; act_period = 0; act_ch = 0; act_duty = 64;
        run_periods("mid_write", 6);
    endtask

    task automatic test_bad_chan();
        act_kind = 1; act_period = 0; act_ch = 5; act_duty = 77;
        run_periods("bad_chan", 2);
    endtask

    task automatic test_soft_stop();
        act_kind = 1; act_period = 0; act_ch = 0; act_duty = 128;
        run_periods("settle", 6);
        act_kind = 2; act_period = 0; act_run = 0;
        run_periods("soft_stop", 16);
        tests_run++;
        if (state !== 2'd0 || m_state != 0) begin
            tests_failed++;
            $display("FAIL soft_stop final state: got %0d (model %0d), required 0", state, m_state);
        end
        check_idle("after_stop", 300);
        start_run("restart");
        run_periods("restart", 14);
    endtask

    task automatic test_stop_resume();
        act_kind = 2; act_period = 0; act_run = 0;
        run_periods("stop_part", 4);
        act_kind = 2; act_period = 0; act_run = 1;
        run_periods("resume", 7);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            act_kind   = 1;
            act_period = 0;
            act_ch     = int'($urandom_range(0, 4));
            act_duty   = int'($urandom_range(0, 255));
            run_periods("random", 2);
        end
        run_periods("random_settle", 17);
    endtask

    task automatic test_reset_midramp();
        act_kind = 1; act_period = 0; act_ch = 2; act_duty = 250;
        run_periods("pre_reset", 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (state !== 2'd0 || busy !== 1'b0 || pwm_out !== 4'b0000 || wr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midramp reset: state=%0d busy=%0b pwm=%b wr_ready=%0b, required 0/0/0000/0",
                     state, busy, pwm_out, wr_ready);
        end
        m_reset();
        rst = 1'b0;
        start_run("post_reset");
        run_periods("post_reset", 2);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_overshoot();
        test_mid_period_write();
        test_bad_chan();
        test_soft_stop();
        test_stop_resume();
        test_random();
        test_reset_midramp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3000000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
